ad7124_sequencer: RTL and testbench

Controller that brings up and runs the AD7124 SPI ADC through a shared SPI transaction engine. After enable it issues the serial reset, programs channel registers and ADC_CONTROL, then polls DOUT/RDY. Each ready conversion is read out as a 24-bit sample tagged with its channel number. It sits between the SPI word engine (which drives sclk/cs/sdi) and the acquisition datapath that consumes dout/valid.

---
 rtl/ad7124_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ad7124_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7124_sequencer.sv
// AD7124 bring-up and conversion readout sequencer driving a shared SPI word engine.
// Issues serial reset, programs CHANNEL_x and ADC_CONTROL, then reads tagged samples on RDY.
module ad7124_sequencer #(
    parameter int          N_CH        = 4,
    parameter logic [15:0] ADC_CTRL    = 16'h04C0,
    parameter int          RST_WAIT    = 4096,
    parameter int          RDY_TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [16*N_CH-1:0]   ch_cfg,
    input  logic                 rdy_n,
    output logic                 spi_start,
    output logic [6:0]           spi_len,
    output logic [63:0]          spi_tx,
    input  logic                 spi_busy,
    input  logic                 spi_done,
    input  logic [31:0]          spi_rx,
    output logic [23:0]          dout,
    output logic [3:0]           chan,
    output logic                 valid,
    output logic                 running,
    output logic                 err_timeout
);

    localparam int WW = $clog2(RST_WAIT + 1);
    localparam int TW = $clog2(RDY_TIMEOUT + 1);
    localparam logic [WW-1:0] W_LAST = WW'(RST_WAIT - 1);
    localparam logic [TW-1:0] T_LAST = TW'(RDY_TIMEOUT - 1);
    localparam logic [4:0]    I_LAST = 5'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE, RST, RST_W, WR_CH, WR_CTRL, WAIT_RDY, RD, ABORT
    } state_t;

    state_t              state;
    logic                rdy_s1, rdy_s2, rdy_prev, outstanding;
    logic [16*N_CH-1:0]  cfg, cfg_sh;
    logic [4:0]          idx;
    logic [WW-1:0]       wcnt;
    logic [TW-1:0]       tcnt;
    logic [6:0]          len_sel;
    logic [63:0]         tx_sel;
    logic                rdy_now;
    logic                unused_rx;

    assign unused_rx = ^spi_rx[7:4];
    assign rdy_now   = !spi_busy && !rdy_s2;
    assign running   = (state == WAIT_RDY) || (state == RD);

    always_comb begin
        len_sel = '0;
        tx_sel  = '0;
        case (state)
            RST:     begin len_sel = 7'd64; tx_sel = '1; end
            WR_CH:   begin len_sel = 7'd24; tx_sel = {8'h09 + {3'b000, idx}, cfg_sh[15:0], 40'h0}; end
            WR_CTRL: begin len_sel = 7'd24; tx_sel = {8'h01, ADC_CTRL, 40'h0}; end
            RD:      begin len_sel = 7'd40; tx_sel = {8'h42, 56'h0}; end
            default: ;
        endcase
    end

    // DOUT/RDY comes straight from the ADC pin, so it is resynchronised before use.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_s1 <= 1'b1;
            rdy_s2 <= 1'b1;
        end else begin
            rdy_s1 <= rdy_n;
            rdy_s2 <= rdy_s1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            outstanding <= 1'b0;
            rdy_prev    <= 1'b0;
            cfg         <= '0;
            cfg_sh      <= '0;
            idx         <= '0;
            wcnt        <= '0;
            tcnt        <= '0;
            spi_start   <= 1'b0;
            spi_len     <= '0;
            spi_tx      <= '0;
            dout        <= '0;
            chan        <= '0;
            valid       <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            valid     <= 1'b0;
            if (state == ABORT) begin
                if (spi_done) begin
                    state       <= IDLE;
                    outstanding <= 1'b0;
                    err_timeout <= 1'b0;
                end
            end else if (!enable && state != IDLE) begin
                // An in-flight transfer must finish before the engine can be reused.
                if (outstanding && !spi_done) begin
                    state <= ABORT;
                end else begin
                    state       <= IDLE;
                    outstanding <= 1'b0;
                    err_timeout <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            cfg         <= ch_cfg;
                            outstanding <= 1'b0;
                            state       <= RST;
                        end
                    end
                    RST, WR_CH, WR_CTRL, RD: begin
                        if (!outstanding) begin
                            if (!spi_busy) begin
                                spi_start   <= 1'b1;
                                spi_len     <= len_sel;
                                spi_tx      <= tx_sel;
                                outstanding <= 1'b1;
                            end
                        end else if (spi_done) begin
                            outstanding <= 1'b0;
                            case (state)
                                RST: begin
                                    wcnt  <= '0;
                                    state <= RST_W;
                                end
                                WR_CH: begin
                                    cfg_sh <= cfg_sh >> 16;
                                    idx    <= idx + 5'd1;
                                    if (idx == I_LAST) state <= WR_CTRL;
                                end
                                WR_CTRL: begin
                                    tcnt     <= '0;
                                    rdy_prev <= 1'b0;
                                    state    <= WAIT_RDY;
                                end
                                default: begin
                                    dout     <= spi_rx[31:8];
                                    chan     <= spi_rx[3:0];
                                    valid    <= 1'b1;
                                    tcnt     <= '0;
                                    rdy_prev <= 1'b0;
                                    state    <= WAIT_RDY;
                                end
                            endcase
                        end
                    end
                    RST_W: begin
                        if (wcnt == W_LAST) begin
                            idx    <= '0;
                            cfg_sh <= cfg;
                            state  <= WR_CH;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    // Two consecutive ready cycles filter single-cycle glitches on RDY.
                    WAIT_RDY: begin
                        rdy_prev <= rdy_now;
                        if (rdy_prev && rdy_now) begin
                            state <= RD;
                        end else if (tcnt == T_LAST) begin
                            err_timeout <= 1'b1;
                            state       <= RST;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad7124_sequencer.sv
// Self-checking bench for ad7124_sequencer: SPI engine model, transaction/valid monitors
// and a reference model of the expected bring-up word sequence.
module tb_ad7124_sequencer;

    localparam int          N_CH        = 4;
    localparam int          RST_WAIT    = 4096;
    localparam int          RDY_TIMEOUT = 100;
    localparam int          XFER        = 10;
    localparam logic [15:0] ADC_CTRL    = 16'h04C0;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        enable = 1'b0;
    logic        rdy_n = 1'b1;
    logic [63:0] ch_cfg = '0;
    logic        spi_start;
    logic [6:0]  spi_len;
    logic [63:0] spi_tx;
    logic        spi_busy = 1'b0;
    logic        spi_done = 1'b0;
    logic [31:0] spi_rx = '0;
    logic [23:0] dout;
    logic [3:0]  chan;
    logic        valid, running, err_timeout;

    logic [31:0] rx_next = '0;
    int          xcnt = 0;
    logic [6:0]  cur_len = '0;
    logic [63:0] cur_tx = '0;
    logic        err_prev = 1'b0;
    int          err_rise = -1;
    int          cyc = 0;
    int          checks = 0, failures = 0, bad_start = 0, hold_err = 0;

    int          st_cyc[$];
    logic [6:0]  st_len[$];
    logic [63:0] st_tx[$];
    int          dn_cyc[$];
    int          v_cyc[$];
    logic [23:0] v_dout[$];
    logic [3:0]  v_chan[$];

    ad7124_sequencer #(
        .N_CH(N_CH), .ADC_CTRL(ADC_CTRL), .RST_WAIT(RST_WAIT), .RDY_TIMEOUT(RDY_TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .ch_cfg(ch_cfg), .rdy_n(rdy_n),
        .spi_start(spi_start), .spi_len(spi_len), .spi_tx(spi_tx), .spi_busy(spi_busy),
        .spi_done(spi_done), .spi_rx(spi_rx), .dout(dout), .chan(chan), .valid(valid),
        .running(running), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI word engine: XFER busy cycles, then a done pulse with the prepared receive word.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spi_busy <= 1'b0;
            spi_done <= 1'b0;
            xcnt     <= 0;
        end else begin
            spi_done <= 1'b0;
            if (spi_busy) begin
                if (xcnt == 1) begin
                    spi_busy <= 1'b0;
                    spi_done <= 1'b1;
                    spi_rx   <= rx_next;
                end
                xcnt <= xcnt - 1;
            end else if (spi_start) begin
                spi_busy <= 1'b1;
                xcnt     <= XFER;
            end
        end
    end

    always @(negedge clk) begin
        if (spi_start) begin
            if (spi_busy) bad_start++;
            st_cyc.push_back(cyc);
            st_len.push_back(spi_len);
            st_tx.push_back(spi_tx);
            cur_len = spi_len;
            cur_tx  = spi_tx;
        end else if (spi_busy && (spi_len !== cur_len || spi_tx !== cur_tx)) begin
            hold_err++;
        end
        if (spi_done) dn_cyc.push_back(cyc);
        if (valid) begin
            v_cyc.push_back(cyc);
            v_dout.push_back(dout);
            v_chan.push_back(chan);
        end
        if (err_timeout && !err_prev) err_rise = cyc;
        err_prev = err_timeout;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (st_len.size() < n && k < budget) begin step(); k++; end
        check_output(tag, 64'(st_len.size() >= n), 64'd1);
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int k = 0;
        while (dn_cyc.size() < n && k < budget) begin step(); k++; end
        check_output(tag, 64'(dn_cyc.size() >= n), 64'd1);
    endtask

    // Reference bring-up: serial reset, CHANNEL_0..N-1 at 0x09+i, then ADC_CONTROL at 0x01.
    task automatic check_init(input int b, input logic [63:0] cfg);
        logic [6:0]  elen;
        logic [63:0] etx;
        for (int i = 0; i < N_CH + 2; i++) begin
            if (i == 0) begin
                elen = 7'd64;
                etx  = ~64'd0;
            end else if (i <= N_CH) begin
                elen = 7'd24;
                etx  = (64'(9 + i - 1) << 56) | (((cfg >> (16 * (i - 1))) & 64'hFFFF) << 40);
            end else begin
                elen = 7'd24;
                etx  = (64'h01 << 56) | (64'(ADC_CTRL) << 40);
            end
            check_output($sformatf("init%0d_len", b + i), 64'(st_len[b + i]), 64'(elen));
            check_output($sformatf("init%0d_tx", b + i), st_tx[b + i], etx);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_output({pfx, "_start"}, 64'(spi_start), 64'd0);
        check_output({pfx, "_len"}, 64'(spi_len), 64'd0);
        check_output({pfx, "_tx"}, spi_tx, 64'd0);
        check_output({pfx, "_dout"}, 64'(dout), 64'd0);
        check_output({pfx, "_chan"}, 64'(chan), 64'd0);
        check_output({pfx, "_valid"}, 64'(valid), 64'd0);
        check_output({pfx, "_running"}, 64'(running), 64'd0);
        check_output({pfx, "_err"}, 64'(err_timeout), 64'd0);
    endtask

    initial begin
        int          gap, base;
        logic [31:0] rx;
        logic [63:0] cfg2;

        #2 resetn = 1'b0;
        repeat (3) step();
        check_reset_outputs("por");

        $display("[TB] bring-up with fixed channel config");
        resetn = 1'b1;
        ch_cfg = {16'h8043, 16'h8022, 16'h8001, 16'h8000};
        enable = 1'b1;
        wait_dones(6, 6000, "init_done_wait");
        check_init(0, ch_cfg);
        gap = st_cyc[1] - dn_cyc[0];
        check_output("rst_wait_gap", 64'(gap >= RST_WAIT && gap <= RST_WAIT + 3), 64'd1);
        step();
        check_output("running_wait_rdy", 64'(running), 64'd1);
        check_output("err_before_timeout", 64'(err_timeout), 64'd0);

        $display("[TB] RDY held high until timeout");
        wait_starts(7, 300, "timeout_reinit_wait");
        check_output("timeout_err", 64'(err_timeout), 64'd1);
        gap = err_rise - dn_cyc[5];
        check_output("timeout_cycle", 64'(gap >= RDY_TIMEOUT && gap <= RDY_TIMEOUT + 2), 64'd1);
        check_output("timeout_before_reinit", 64'(err_rise <= st_cyc[6]), 64'd1);
        wait_dones(12, 6000, "reinit_done_wait");
        check_init(6, ch_cfg);

        $display("[TB] conversion readout with random data");
        for (int k = 0; k < 6; k++) begin
            rx = (k == 0) ? 32'hABCDEF32 : $urandom;
            rx_next = rx;
            rdy_n = 1'b0;
            wait_starts(13 + k, 60, $sformatf("rd%0d_start_wait", k));
            if (k == 5) rdy_n = 1'b1;
            check_output($sformatf("rd%0d_len", k), 64'(st_len[12 + k]), 64'd40);
            check_output($sformatf("rd%0d_tx", k), st_tx[12 + k], {8'h42, 56'h0});
            wait_dones(13 + k, 60, $sformatf("rd%0d_done_wait", k));
            step();
            step();
            check_output($sformatf("rd%0d_valid_count", k), 64'(v_cyc.size()), 64'(k + 1));
            check_output($sformatf("rd%0d_latency", k), 64'(v_cyc[k] - dn_cyc[12 + k]), 64'd1);
            check_output($sformatf("rd%0d_dout", k), 64'(v_dout[k]), 64'(rx[31:8]));
            check_output($sformatf("rd%0d_chan", k), 64'(v_chan[k]), 64'(rx[3:0]));
        end

        $display("[TB] single-cycle RDY glitch");
        rdy_n = 1'b0;
        step();
        rdy_n = 1'b1;
        repeat (20) step();
        check_output("glitch_no_rd", 64'(st_len.size()), 64'd18);
        check_output("glitch_running", 64'(running), 64'd1);
        check_output("err_sticky", 64'(err_timeout), 64'd1);

        $display("[TB] enable dropped during a read");
        rdy_n = 1'b0;
        wait_starts(19, 30, "abort_rd_start_wait");
        rdy_n = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        wait_dones(19, 30, "abort_done_wait");
        repeat (4) step();
        check_output("abort_no_start", 64'(st_len.size()), 64'd19);
        check_output("abort_no_valid", 64'(v_cyc.size()), 64'd6);
        check_output("abort_idle", 64'(running), 64'd0);
        check_output("abort_err_clear", 64'(err_timeout), 64'd0);

        $display("[TB] reset during channel programming");
        cfg2   = {$urandom, $urandom};
        ch_cfg = cfg2;
        enable = 1'b1;
        wait_starts(21, 6000, "wrch_start_wait");
        repeat (4) step();
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        base = st_len.size();
        step();
        resetn = 1'b1;
        step();
        step();
        ch_cfg = ~cfg2;
        wait_starts(base + N_CH + 2, 6000, "restart_wait");
        check_init(base, cfg2);

        check_output("no_start_while_busy", 64'(bad_start), 64'd0);
        check_output("len_tx_held", 64'(hold_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
